reset_sequencer: RTL and testbench
==================================

Name: reset_sequencer

Overview:
- Parametrised successor to the single-PLL reset buffer.
- Takes the PLL LOCK and an external active-low reset request.
- Synchronises both, waits for a programmable stable-lock period, then releases NUM_CHANNELS active-high resets one at a time with a programmable stagger.
- Sits between the PLL instance and the core subsystems (flash driver, CPU, peripherals); re-asserts all resets on lock loss and counts lock-loss events.

Parameters:
- NUM_CHANNELS, 4: number of reset outputs; >=1.
- SYNC_STAGES, 2: synchroniser depth for lock/ext reset; >=2.
- STABLE_CYCLES, 16: cycles lock must stay high before first release; >=1.
- STAGGER_CYCLES, 4: cycles between successive channel releases; >=1.
- LOCK_TIMEOUT, 4096: HOLD cycles before PLL retry (optional feature only); >=2.

Ports:
- clk_in  input  1  PLL output clock; all logic on posedge.
- reset_in  input  1  asynchronous active-high reset.
- lock_in  input  1  PLL LOCK, asynchronous to clk_in.
- ext_resetb_in  input  1  external reset button, active-low, asynchronous.
- reset_out  output  NUM_CHANNELS  per-channel active-high reset; bit 0 released first.
- all_released_out  output  1  high when every reset_out bit is 0 (state RUN).
- lock_loss_count  output  8  saturating count of lock losses after first release.
- pll_resetb_out  output  1  active-low PLL reset request; constant 1 unless the feature is enabled.

Behaviour:
- Reset, async on reset_in high:
  - state=HOLD, reset_out all 1s, all_released_out=0, lock_loss_count=0, pll_resetb_out=1.
  - All counters and synchroniser flops are 0.
- Synchroniser: lock_s = (lock_in & ext_resetb_in) passed through SYNC_STAGES flops.
- Everything below uses lock_s only.
- HOLD:
  - reset_out all 1s; counter held at 0.
  - lock_s=1 -> STABLE, counter=0.
- STABLE:
  - Counter increments each edge.
  - lock_s=0 -> HOLD, no count increment.
  - At the edge where counter==STABLE_CYCLES-1: clear reset_out[0], idx=0, counter=0, go to RELEASE.
  - If NUM_CHANNELS==1, go directly to RUN on that edge.
- RELEASE:
  - Counter increments; when counter==STAGGER_CYCLES-1, clear reset_out[idx+1], idx++, counter=0.
  - The edge that clears bit NUM_CHANNELS-1 also enters RUN and sets all_released_out=1.
- RUN: hold while lock_s=1.
- Lock loss (lock_s=0 sampled in RELEASE or RUN), on the next edge:
  - reset_out all 1s, all_released_out=0, state=HOLD.
  - lock_loss_count increments, saturating at 255.
- Lock loss in STABLE does not count.
- Deasserted bits never re-assert individually; reset_out only ever changes from all-1s toward 0 in index order, or back to all-1s.
- Latency from lock_in rising (with ext_resetb_in=1, setup met before edge 1):
  - reset_out[i] falls at edge SYNC_STAGES+1+STABLE_CYCLES+i*STAGGER_CYCLES.
  - Defaults: edges 19, 23, 27, 31; all_released_out rises at edge 31.
- Counter widths are $clog2 of the relevant parameter, minimum 1 bit; no wrap within a state.
- Mid-sequence reset_in assertion immediately forces all outputs to reset values; sequencing restarts from HOLD.

Optional Feature:
- Macro: RESET_SEQ_WATCHDOG_EN.
- Defined:
  - A timeout counter runs only in HOLD and clears on leaving HOLD.
  - When it reaches LOCK_TIMEOUT-1, pll_resetb_out is driven 0 for exactly 8 cycles, then returns to 1 and the counter restarts from 0.
  - Leaving HOLD during the pulse does not truncate the pulse.
- Undefined: pll_resetb_out is tied 1 and no timeout logic exists.

Test Plan:
- Default params, reset_in pulse, lock_in=1 and ext_resetb_in=1 from edge 0 -> reset_out 4'b1111 until edge 18; 4'b1110 @19, 4'b1100 @23, 4'b1000 @27, 4'b0000 @31; all_released_out=1 @31.
- lock_in drops for 1 cycle at STABLE counter=10 -> back to HOLD, lock_loss_count stays 0; full STABLE_CYCLES period restarts after relock.
- In RUN, ext_resetb_in=0 for 3 cycles -> after SYNC_STAGES+1 edges reset_out=4'b1111, all_released_out=0, lock_loss_count=1; resequences after release.
- 300 lock-loss events in RUN -> lock_loss_count saturates at 255.
- reset_in asserted asynchronously mid-RELEASE (reset_out=4'b1100) -> outputs immediately 4'b1111, all_released_out=0, count 0, with no clock edge required.
- RESET_SEQ_WATCHDOG_EN, LOCK_TIMEOUT=32, lock_in held 0 -> pll_resetb_out low for 8 cycles every 40 cycles; without the macro, pll_resetb_out stays 1 throughout.

Source files
------------

// File: rtl/reset_sequencer.sv
// reset_sequencer
//   Staggered multi-channel reset release gated by a stable PLL lock.
//   lock_in & ext_resetb_in is synchronised into clk_in, must stay high for
//   STABLE_CYCLES, then reset_out bits drop one at a time (bit 0 first) every
//   STAGGER_CYCLES. Any loss of the synchronised lock after the first release
//   re-asserts every channel and bumps a saturating event counter.
//
// Optional feature (macro RESET_SEQ_WATCHDOG_EN):
//   While stuck in HOLD for LOCK_TIMEOUT cycles, pulse pll_resetb_out low for
//   8 cycles to kick the PLL, then start timing again. Without the macro
//   pll_resetb_out is tied high.
//
// Ports:
//   clk_in           in   PLL output clock, posedge
//   reset_in         in   async active-high reset
//   lock_in          in   PLL LOCK (async)
//   ext_resetb_in    in   external reset button, active-low (async)
//   reset_out        out  [NUM_CHANNELS] active-high channel resets
//   all_released_out out  high in RUN (every channel released)
//   lock_loss_count  out  [8] saturating lock-loss count
//   pll_resetb_out   out  active-low PLL reset request
module reset_sequencer #(
  parameter int NUM_CHANNELS   = 4,
  parameter int SYNC_STAGES    = 2,
  parameter int STABLE_CYCLES  = 16,
  parameter int STAGGER_CYCLES = 4,
  parameter int LOCK_TIMEOUT   = 4096
) (
  input  logic                    clk_in,
  input  logic                    reset_in,
  input  logic                    lock_in,
  input  logic                    ext_resetb_in,
  output logic [NUM_CHANNELS-1:0] reset_out,
  output logic                    all_released_out,
  output logic [7:0]              lock_loss_count,
  output logic                    pll_resetb_out
);

  localparam int SBW = (STABLE_CYCLES  > 1) ? $clog2(STABLE_CYCLES)  : 1;
  localparam int SGW = (STAGGER_CYCLES > 1) ? $clog2(STAGGER_CYCLES) : 1;
  localparam int CW  = (SBW > SGW) ? SBW : SGW;
  localparam int IW  = (NUM_CHANNELS   > 1) ? $clog2(NUM_CHANNELS)   : 1;

  localparam logic [CW-1:0] STB_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] STG_LAST = CW'(STAGGER_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_CHANNELS - 1);

  if (NUM_CHANNELS < 1 || SYNC_STAGES < 2 || STABLE_CYCLES < 1 ||
      STAGGER_CYCLES < 1 || LOCK_TIMEOUT < 2) begin : g_bad_param
    $error("reset_sequencer: parameter out of range");
  end

  typedef enum logic [1:0] {HOLD, STABLE, RELEASE, RUN} state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [IW-1:0]           idx_q, idx_d, idx_nxt;
  logic [NUM_CHANNELS-1:0] rst_q, rst_d;
  logic                    rel_q, rel_d;
  logic [7:0]              llc_q, llc_d;
  logic [SYNC_STAGES-1:0]  sync_q;
  logic                    lock_s;

  // Both async sources are merged before synchronising: either dropping is a loss.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) sync_q <= '0;
    else          sync_q <= {sync_q[SYNC_STAGES-2:0], lock_in & ext_resetb_in};
  end
  assign lock_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      state_q <= HOLD;
      cnt_q   <= '0;
      idx_q   <= '0;
      rst_q   <= '1;
      rel_q   <= 1'b0;
      llc_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      rst_q   <= rst_d;
      rel_q   <= rel_d;
      llc_q   <= llc_d;
    end
  end

  assign idx_nxt = idx_q + 1'b1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    rst_d   = rst_q;
    rel_d   = rel_q;
    llc_d   = llc_q;
    case (state_q)
      HOLD: begin
        rst_d = '1;
        rel_d = 1'b0;
        cnt_d = '0;
        idx_d = '0;
        if (lock_s) state_d = STABLE;
      end
      STABLE: begin
        if (!lock_s) begin
          // No channel has been released yet, so this is not a counted loss.
          state_d = HOLD;
          cnt_d   = '0;
        end else if (cnt_q == STB_LAST) begin
          rst_d[0] = 1'b0;
          idx_d    = '0;
          cnt_d    = '0;
          if (NUM_CHANNELS == 1) begin
            state_d = RUN;
            rel_d   = 1'b1;
          end else begin
            state_d = RELEASE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RELEASE, RUN: begin
        if (!lock_s) begin
          state_d = HOLD;
          rst_d   = '1;
          rel_d   = 1'b0;
          cnt_d   = '0;
          idx_d   = '0;
          if (llc_q != 8'hFF) llc_d = llc_q + 8'd1;
        end else if (state_q == RELEASE) begin
          if (cnt_q == STG_LAST) begin
            for (int i = 0; i < NUM_CHANNELS; i++)
              if (IW'(i) == idx_nxt) rst_d[i] = 1'b0;
            idx_d = idx_nxt;
            cnt_d = '0;
            if (idx_nxt == IDX_LAST) begin
              state_d = RUN;
              rel_d   = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = HOLD;
    endcase
  end

  assign reset_out        = rst_q;
  assign all_released_out = rel_q;
  assign lock_loss_count  = llc_q;

`ifdef RESET_SEQ_WATCHDOG_EN
  localparam int WW = $clog2(LOCK_TIMEOUT);
  localparam logic [WW-1:0] WD_LAST = WW'(LOCK_TIMEOUT - 1);

  logic [WW-1:0] wd_cnt_q;
  logic [2:0]    pcnt_q;
  logic          pulse_q;

  // The pulse runs to completion regardless of state; the timeout counter
  // is parked at 0 while pulsing and outside HOLD.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      wd_cnt_q <= '0;
      pcnt_q   <= '0;
      pulse_q  <= 1'b0;
    end else if (pulse_q) begin
      wd_cnt_q <= '0;
      pcnt_q   <= pcnt_q + 3'd1;
      if (pcnt_q == 3'd7) pulse_q <= 1'b0;
    end else if (state_q == HOLD) begin
      if (wd_cnt_q == WD_LAST) begin
        wd_cnt_q <= '0;
        pcnt_q   <= '0;
        pulse_q  <= 1'b1;
      end else begin
        wd_cnt_q <= wd_cnt_q + 1'b1;
      end
    end else begin
      wd_cnt_q <= '0;
    end
  end

  assign pll_resetb_out = ~pulse_q;
`else
  assign pll_resetb_out = 1'b1;
`endif

endmodule

// File: tb/tb_reset_sequencer.sv
module tb_reset_sequencer;
  localparam int N = 4;

  logic         clk_in = 1'b0;
  logic         reset_in, lock_in, ext_resetb_in;
  logic [N-1:0] reset_out;
  logic         all_released_out;
  logic [7:0]   lock_loss_count;
  logic         pll_resetb_out;

  int npass  = 0;
  int ntotal = 0;
  int exp_llc;
  logic pll_low_seen = 1'b0;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;
  exp_t sb[$];

  always #5 clk_in = ~clk_in;

  reset_sequencer #(
    .NUM_CHANNELS(N), .SYNC_STAGES(2), .STABLE_CYCLES(16),
    .STAGGER_CYCLES(4), .LOCK_TIMEOUT(32)
  ) dut (
    .clk_in(clk_in), .reset_in(reset_in), .lock_in(lock_in),
    .ext_resetb_in(ext_resetb_in), .reset_out(reset_out),
    .all_released_out(all_released_out), .lock_loss_count(lock_loss_count),
    .pll_resetb_out(pll_resetb_out)
  );

  // Monitor for the build without the watchdog: pll_resetb_out must never drop.
  always @(negedge clk_in) if (pll_resetb_out !== 1'b1) pll_low_seen = 1'b1;

  task automatic push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic chk(input logic [31:0] obs);
    exp_t e;
    ntotal++;
    if (sb.size() == 0) begin
      $display("FAIL scoreboard_empty: observed %0h, no expected value", obs);
      return;
    end
    e = sb.pop_front();
    assert (obs === e.val) npass++;
    else $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.val);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  // Release reset on a falling edge with lock already high: next posedge is edge 1.
  task automatic start_seq();
    @(negedge clk_in);
    reset_in      = 1'b0;
    lock_in       = 1'b1;
    ext_resetb_in = 1'b1;
  endtask

  initial begin
    reset_in = 1'b1; lock_in = 1'b0; ext_resetb_in = 1'b1;

    // Reset state
    push("rst_reset_out", 32'hF); push("rst_all_rel", 0);
    push("rst_llc", 0);           push("rst_pll", 1);
    #23;
    chk(32'(reset_out)); chk(32'(all_released_out));
    chk(32'(lock_loss_count)); chk(32'(pll_resetb_out));

    // Nominal release timing: 19/23/27/31
    start_seq();
    push("t1_e18", 32'hF); push("t1_e18_rel", 0);
    push("t1_e19", 32'hE); push("t1_e23", 32'hC); push("t1_e27", 32'h8);
    push("t1_e30_rel", 0); push("t1_e31", 32'h0); push("t1_e31_rel", 1);
    step(18); chk(32'(reset_out)); chk(32'(all_released_out));
    step(1);  chk(32'(reset_out));
    step(4);  chk(32'(reset_out));
    step(4);  chk(32'(reset_out));
    step(3);  chk(32'(all_released_out));
    step(1);  chk(32'(reset_out)); chk(32'(all_released_out));

    // Lock glitch while STABLE counter is 10: uncounted, full restart
    reset_in = 1'b1;
    #1;
    start_seq();
    push("t2_e30", 32'hF); push("t2_e30_llc", 0); push("t2_e31", 32'hE);
    push("t2_e43", 32'h0); push("t2_e43_rel", 1); push("t2_e43_llc", 0);
    step(11); lock_in = 1'b0;
    step(1);  lock_in = 1'b1;
    step(18); chk(32'(reset_out)); chk(32'(lock_loss_count));
    step(1);  chk(32'(reset_out));
    step(12); chk(32'(reset_out)); chk(32'(all_released_out)); chk(32'(lock_loss_count));

    // External reset for 3 cycles in RUN
    push("t3_e45", 32'h0); push("t3_e46", 32'hF); push("t3_e46_rel", 0);
    push("t3_e46_llc", 1); push("t3_e64", 32'hF); push("t3_e65", 32'hE);
    push("t3_e77", 32'h0); push("t3_e77_rel", 1);
    ext_resetb_in = 1'b0;
    step(2);  chk(32'(reset_out));
    step(1);  ext_resetb_in = 1'b1;
    chk(32'(reset_out)); chk(32'(all_released_out)); chk(32'(lock_loss_count));
    step(18); chk(32'(reset_out));
    step(1);  chk(32'(reset_out));
    step(12); chk(32'(reset_out)); chk(32'(all_released_out));

    // 299 further losses in RUN (300 total): counter saturates at 255
    exp_llc = 1;
    for (int i = 0; i < 299; i++) begin
      lock_in = 1'b0;
      step(1);
      lock_in = 1'b1;
      exp_llc = (exp_llc == 255) ? 255 : exp_llc + 1;
      push("t4_llc", 32'(exp_llc)); push("t4_reset_out", 32'hF);
      step(2);
      chk(32'(lock_loss_count)); chk(32'(reset_out));
      step(29);
    end
    push("t4_final_rel", 1); push("t4_final_llc", 255);
    chk(32'(all_released_out)); chk(32'(lock_loss_count));

    // Async reset mid-RELEASE with reset_out=1100, no clock edge needed
    push("t5_mid", 32'hC); push("t5_reset_out", 32'hF); push("t5_rel", 0);
    push("t5_llc", 0);     push("t5_pll", 1);
    lock_in = 1'b0;
    step(1);
    lock_in = 1'b1;
    step(23); chk(32'(reset_out));
    #2 reset_in = 1'b1;
    #1;
    chk(32'(reset_out)); chk(32'(all_released_out));
    chk(32'(lock_loss_count)); chk(32'(pll_resetb_out));

    // Lock held low in HOLD for 80 cycles: watchdog pulse pattern
    lock_in = 1'b0;
    @(negedge clk_in);
    reset_in = 1'b0;
    for (int k = 1; k <= 80; k++) begin
`ifdef RESET_SEQ_WATCHDOG_EN
      push("t6_pll", ((k >= 32 && k < 40) || (k >= 72 && k < 80)) ? 0 : 1);
`else
      push("t6_pll", 1);
`endif
      step(1);
      chk(32'(pll_resetb_out));
    end
    push("t6_hold_reset_out", 32'hF);
    chk(32'(reset_out));
`ifndef RESET_SEQ_WATCHDOG_EN
    push("pll_never_low", 0);
    chk(32'(pll_low_seen));
`endif

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end
endmodule
